// File: rtl/uart_dce_loopback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_dce_loopback                                             |
// | Purpose  : UART DCE-side loopback. Receives 8N1 characters from the DTE  |
// |            on txd, queues them in an echo FIFO and sends them back,      |
// |            unchanged and in order, on rxd. Paces the DTE with cts,       |
// |            obeys the DTE's rts, and publishes its baud divisor on DBR.   |
// | Ports    : clock   in   system clock, rising edge                       |
// |            reset_n in   asynchronous active-low reset                   |
// |            rts     in   DTE ready-to-receive (1 = may start an echo)    |
// |            cts     out  clear-to-send to DTE (1 = can accept chars)     |
// |            txd     in   serial data from DTE, idle 1, asynchronous      |
// |            rxd     out  serial data to DTE, idle 1                      |
// |            DBR     out  baud divisor (CLK_PER_BIT), zero-extended       |
// | Revision : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module uart_dce_loopback #(
  parameter int unsigned CLK_PER_BIT = 87,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned CTS_MARGIN  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rts,
  output logic        cts,
  input  logic        txd,
  output logic        rxd,
  output logic [31:0] DBR
);

  localparam int unsigned c_baud_w = $clog2(CLK_PER_BIT);
  localparam int unsigned c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int unsigned c_cnt_w  = c_ptr_w + 1;

  localparam logic [c_baud_w-1:0] c_bit_reload  = c_baud_w'(CLK_PER_BIT - 1);
  localparam logic [c_baud_w-1:0] c_half_reload = c_baud_w'(CLK_PER_BIT / 2 - 1);
  localparam logic [c_baud_w-1:0] c_baud_one    = c_baud_w'(1);
  localparam logic [c_cnt_w-1:0]  c_cnt_full    = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0]  c_cnt_one     = c_cnt_w'(1);
  // free >= CTS_MARGIN  <=>  count <= FIFO_DEPTH - CTS_MARGIN
  localparam logic [c_cnt_w-1:0]  c_cts_limit   = c_cnt_w'(FIFO_DEPTH - CTS_MARGIN);

  localparam logic [2:0] c_rx_idle  = 3'd0;
  localparam logic [2:0] c_rx_start = 3'd1;
  localparam logic [2:0] c_rx_data  = 3'd2;
  localparam logic [2:0] c_rx_stop  = 3'd3;
  localparam logic [2:0] c_rx_break = 3'd4;  // framing error: wait for txd=1

  localparam logic [1:0] c_tx_idle  = 2'd0;
  localparam logic [1:0] c_tx_start = 2'd1;
  localparam logic [1:0] c_tx_data  = 2'd2;
  localparam logic [1:0] c_tx_stop  = 2'd3;

  assign DBR = 32'(CLK_PER_BIT);

  // ---------------------------------------------------------------- txd sync
  logic r_txd_meta;
  logic r_txd_sync;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_txd_meta <= 1'b1;
      r_txd_sync <= 1'b1;
    end else begin
      r_txd_meta <= txd;
      r_txd_sync <= r_txd_meta;
    end
  end

  // ------------------------------------------------------------------ RX FSM
  logic [2:0]          r_rx_state;
  logic [2:0]          w_rx_state_nxt;
  logic [c_baud_w-1:0] r_rx_baud;
  logic [2:0]          r_rx_bit;
  logic [7:0]          r_rx_shift;
  logic                w_rx_tick;
  logic                w_rx_push;

  assign w_rx_tick = (r_rx_baud == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rx_state <= c_rx_idle;
    else          r_rx_state <= w_rx_state_nxt;
  end

  // txd is known high whenever IDLE is entered, so a low level in IDLE is
  // the 1->0 start edge.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      c_rx_idle:  if (!r_txd_sync) w_rx_state_nxt = c_rx_start;
      c_rx_start: if (w_rx_tick) w_rx_state_nxt = r_txd_sync ? c_rx_idle : c_rx_data;
      c_rx_data:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_state_nxt = c_rx_stop;
      c_rx_stop:  if (w_rx_tick) w_rx_state_nxt = r_txd_sync ? c_rx_idle : c_rx_break;
      c_rx_break: if (r_txd_sync) w_rx_state_nxt = c_rx_idle;
      default:    w_rx_state_nxt = c_rx_idle;
    endcase
  end

  always_comb begin
    w_rx_push = (r_rx_state == c_rx_stop) && w_rx_tick && r_txd_sync;
  end

  // IDLE keeps the half-bit reload armed so START begins already loaded.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        c_rx_idle: begin
          r_rx_baud <= c_half_reload;
          r_rx_bit  <= '0;
        end
        c_rx_start, c_rx_stop: begin
          r_rx_baud <= w_rx_tick ? c_bit_reload : r_rx_baud - c_baud_one;
        end
        c_rx_data: begin
          if (w_rx_tick) begin
            r_rx_shift <= {r_txd_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            r_rx_baud  <= c_bit_reload;
          end else begin
            r_rx_baud <= r_rx_baud - c_baud_one;
          end
        end
        default: r_rx_baud <= '0;
      endcase
    end
  end

  // -------------------------------------------------------------- echo FIFO
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_cnt_w-1:0] w_count_nxt;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               r_cts;

  assign w_full  = (r_count == c_cnt_full);
  assign w_empty = (r_count == '0);
  // Overrun: a byte arriving while full is dropped.
  assign w_push  = w_rx_push && !w_full;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_cnt_one;
      2'b01:   w_count_nxt = r_count - c_cnt_one;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= r_rx_shift;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_cts    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      r_count <= w_count_nxt;
      r_cts   <= (w_count_nxt <= c_cts_limit);
    end
  end

  assign cts = r_cts;

  // ------------------------------------------------------------------ TX FSM
  logic [1:0]          r_tx_state;
  logic [1:0]          w_tx_state_nxt;
  logic [c_baud_w-1:0] r_tx_baud;
  logic [2:0]          r_tx_bit;
  logic [7:0]          r_tx_shift;
  logic                w_tx_tick;

  assign w_tx_tick = (r_tx_baud == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_tx_state <= c_tx_idle;
    else          r_tx_state <= w_tx_state_nxt;
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      c_tx_idle:  if (w_pop) w_tx_state_nxt = c_tx_start;
      c_tx_start: if (w_tx_tick) w_tx_state_nxt = c_tx_data;
      c_tx_data:  if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_state_nxt = c_tx_stop;
      c_tx_stop:  if (w_tx_tick) w_tx_state_nxt = c_tx_idle;
      default:    w_tx_state_nxt = c_tx_idle;
    endcase
  end

  // rts only matters in IDLE; a character in flight always completes.
  always_comb begin
    w_pop = (r_tx_state == c_tx_idle) && !w_empty && rts;
    rxd   = 1'b1;
    case (r_tx_state)
      c_tx_start: rxd = 1'b0;
      c_tx_data:  rxd = r_tx_shift[0];
      default:    rxd = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else begin
      case (r_tx_state)
        c_tx_idle: begin
          if (w_pop) begin
            r_tx_shift <= r_mem[r_rd_ptr];
            r_tx_baud  <= c_bit_reload;
            r_tx_bit   <= '0;
          end
        end
        c_tx_start, c_tx_stop: begin
          r_tx_baud <= w_tx_tick ? c_bit_reload : r_tx_baud - c_baud_one;
        end
        c_tx_data: begin
          if (w_tx_tick) begin
            r_tx_shift <= {1'b1, r_tx_shift[7:1]};
            r_tx_bit   <= r_tx_bit + 3'd1;
            r_tx_baud  <= c_bit_reload;
          end else begin
            r_tx_baud <= r_tx_baud - c_baud_one;
          end
        end
        default: r_tx_baud <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_dce_loopback.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_dce_loopback                                          |
// | Purpose  : Self-checking bench for uart_dce_loopback: DTE-side serial    |
// |            sender, rxd frame decoder and rxd edge logger.                |
// | Revision : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_dce_loopback;

  localparam int c_bit = 87;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rts;
  logic        cts;
  logic        txd;
  logic        rxd;
  logic [31:0] dbr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] rx_q [$];   // bytes decoded from rxd
  int         edge_q [$]; // cycle stamps of rxd transitions
  logic       rxd_prev = 1'b1;
  logic [7:0] mon_b;

  typedef struct {
    logic [7:0] data;
    int         per;   // DTE clocks per bit
    logic       stop;  // stop bit level driven
    logic       echo;  // echo expected
  } vec_t;

  vec_t vecs [6];

  uart_dce_loopback dut (
    .clock   (clk),
    .reset_n (rst_n),
    .rts     (rts),
    .cts     (cts),
    .txd     (txd),
    .rxd     (rxd),
    .DBR     (dbr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(1_500_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rxd !== rxd_prev) edge_q.push_back(cyc);
      rxd_prev = rxd;
    end
  end

  // rxd decoder: samples each bit at its centre.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rxd === 1'b0) begin
        repeat (c_bit / 2) @(negedge clk);
        if (rxd === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (c_bit) @(negedge clk);
            mon_b[i] = rxd;
          end
          repeat (c_bit) @(negedge clk);
          if (rxd === 1'b1) rx_q.push_back(mon_b);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int per, input logic stop);
    txd = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      txd = d[i];
      repeat (per) @(negedge clk);
    end
    txd = stop;
    repeat (per) @(negedge clk);
    txd = 1'b1;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic clear_logs();
    rx_q.delete();
    edge_q.delete();
  endtask

  initial begin
    int t0;
    int lat;
    int k;

    vecs[0] = '{data: 8'hA3, per: 87, stop: 1'b1, echo: 1'b1};
    vecs[1] = '{data: 8'h00, per: 87, stop: 1'b1, echo: 1'b1};
    vecs[2] = '{data: 8'hFF, per: 84, stop: 1'b1, echo: 1'b1};  // fast DTE
    vecs[3] = '{data: 8'h96, per: 90, stop: 1'b1, echo: 1'b1};  // slow DTE
    vecs[4] = '{data: 8'h3C, per: 87, stop: 1'b0, echo: 1'b0};  // framing error
    vecs[5] = '{data: 8'hC3, per: 87, stop: 1'b1, echo: 1'b1};

    // ---- reset and idle
    rst_n = 1'b0;
    rts   = 1'b0;
    txd   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rxd", rxd, 1);
    check("reset_cts", cts, 0);
    check("reset_dbr", dbr, 87);
    rst_n = 1'b1;
    check("cts_before_first_clock", cts, 0);
    @(negedge clk);
    check("cts_after_first_clock", cts, 1);
    clear_logs();
    repeat (200) @(negedge clk);
    check("idle_rxd_edges", edge_q.size(), 0);

    // ---- single echo with timing
    rts = 1'b1;
    clear_logs();
    t0 = cyc;
    send_frame(8'h55, c_bit, 1'b1);
    wait_rx(1, 1100);
    repeat (20) @(negedge clk);
    check("echo55_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) check("echo55_data", rx_q[0], 8'h55);
    check("echo55_edges", edge_q.size(), 10);
    if (edge_q.size() >= 10) begin
      // DTE stop-bit centre is +826.5; the 2-flop sync puts the stop sample
      // near +829, and the echo start may follow it by up to 3 clocks.
      lat = edge_q[0] - t0;
      check($sformatf("echo55_latency(%0d)", lat), (lat >= 827 && lat <= 832), 1);
      for (int i = 0; i < 9; i++)
        check($sformatf("echo55_bitwidth_%0d", i), edge_q[i+1] - edge_q[i], c_bit);
    end

    // ---- table-driven frames
    for (int v = 0; v < 6; v++) begin
      clear_logs();
      send_frame(vecs[v].data, vecs[v].per, vecs[v].stop);
      repeat (c_bit) @(negedge clk);
      wait_rx(1, 1000);
      repeat (20) @(negedge clk);
      check($sformatf("vec%0d_count", v), rx_q.size(), vecs[v].echo ? 1 : 0);
      if (vecs[v].echo && rx_q.size() >= 1)
        check($sformatf("vec%0d_data", v), rx_q[0], vecs[v].data);
    end

    // ---- start-bit glitch
    clear_logs();
    txd = 1'b0;
    repeat (20) @(negedge clk);
    txd = 1'b1;
    repeat (1200) @(negedge clk);
    check("glitch_no_echo", rx_q.size() + edge_q.size(), 0);

    // ---- burst with flow control
    rts = 1'b0;
    clear_logs();
    for (int i = 0; i < 14; i++) send_frame(8'(i), c_bit, 1'b1);
    check("burst_cts_after_14", cts, 1);
    send_frame(8'h0E, c_bit, 1'b1);
    repeat (5) @(negedge clk);
    check("burst_cts_after_15", cts, 0);
    check("burst_rxd_quiet", edge_q.size(), 0);
    rts = 1'b1;
    wait_rx(15, 15 * 880 + 500);
    repeat (200) @(negedge clk);
    check("burst_count", rx_q.size(), 15);
    for (int i = 0; i < 15; i++)
      if (i < rx_q.size()) check($sformatf("burst_byte_%0d", i), rx_q[i], 8'(i));

    // ---- overrun
    rts = 1'b0;
    clear_logs();
    for (int i = 0; i < 17; i++) send_frame(8'hA0 + 8'(i), c_bit, 1'b1);
    rts = 1'b1;
    wait_rx(16, 16 * 880 + 500);
    repeat (300) @(negedge clk);
    check("overrun_count", rx_q.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < rx_q.size()) check($sformatf("overrun_byte_%0d", i), rx_q[i], 8'hA0 + 8'(i));

    // ---- reset during echo data bit 4 (0x0F: bit 4 is 0)
    rts = 1'b0;
    clear_logs();
    send_frame(8'h0F, c_bit, 1'b1);
    send_frame(8'h11, c_bit, 1'b1);
    rts = 1'b1;
    k = 0;
    while (rxd === 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("midrst_echo_started", rxd, 0);
    repeat (5 * c_bit + c_bit / 2) @(negedge clk);
    check("midrst_bit4_low", rxd, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_rxd_high", rxd, 1);
    check("midrst_cts_low", cts, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    clear_logs();
    repeat (2000) @(negedge clk);
    check("midrst_no_echo", rx_q.size() + edge_q.size(), 0);
    check("midrst_cts_high", cts, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
